systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 129 ++++++++++++
 tb/tb_systolic_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for a 4x4 systolic array: buffers A and B, then
// streams row r of A delayed by r beats and column c of B delayed by c beats.

module systolic_feeder_lane #(
  parameter int DW   = 32,
  parameter int LANE = 0
) (
  input  logic [2:0]         k_i,
  input  logic [3:0][DW-1:0] elem_i,
  output logic [DW-1:0]      data_o
);
  logic [3:0] off;

  always_comb begin
    off    = {1'b0, k_i} - 4'(LANE);
    data_o = '0;
    if (k_i >= 3'(LANE) && off <= 4'd3) data_o = elem_i[off[1:0]];
  end
endmodule

module systolic_feeder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_4,
  output logic [DATA_WIDTH-1:0] left_o_8,
  output logic [DATA_WIDTH-1:0] left_o_12,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3
);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic                ld_beat;
  logic                busy_q, done_q;
  logic [15:0][DW-1:0] a_q, b_q;
  logic [3:0][DW-1:0]  left_q, up_q, left_d, up_d;
  logic [3:0][DW-1:0]  left_beat, up_beat;
  logic [3:0][3:0][DW-1:0] col_elem;
  logic                wr_ok;

  // Writes only land while idle and not colliding with an accepted start.
  assign wr_ok = (state_q == IDLE) && wr_en_i && !start_i;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ld_beat = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = STREAM;
        k_d     = 3'd0;
        ld_beat = 1'b1;
      end
      STREAM: if (k_q == 3'd6) begin
        state_d = DONE;
        k_d     = 3'd0;
      end else begin
        k_d     = k_q + 3'd1;
        ld_beat = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lanes look at the next beat index so the outputs register the beat.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    for (genvar j = 0; j < 4; j++) begin : g_col
      assign col_elem[l][j] = b_q[4*j + l];
    end
    systolic_feeder_lane #(.DW(DW), .LANE(l)) u_row (
      .k_i(k_d), .elem_i(a_q[4*l +: 4]), .data_o(left_beat[l])
    );
    systolic_feeder_lane #(.DW(DW), .LANE(l)) u_col (
      .k_i(k_d), .elem_i(col_elem[l]), .data_o(up_beat[l])
    );
  end

  assign left_d = ld_beat ? left_beat : '0;
  assign up_d   = ld_beat ? up_beat   : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      up_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d == STREAM);
      done_q  <= (state_d == DONE);
      left_q  <= left_d;
      up_q    <= up_d;
      if (wr_ok && !wr_sel_i) a_q[wr_addr_i] <= wr_data_i;
      if (wr_ok &&  wr_sel_i) b_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign left_o_0  = left_q[0];
  assign left_o_4  = left_q[1];
  assign left_o_8  = left_q[2];
  assign left_o_12 = left_q[3];
  assign up_o_0    = up_q[0];
  assign up_o_1    = up_q[1];
  assign up_o_2    = up_q[2];
  assign up_o_3    = up_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder, including a small 4x4 MAC array fed
// by the streams to confirm the skew produces A*B.

module tb_systolic_feeder;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, wr_sel, start, busy, done;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0][DW-1:0] left_s, up_s;

  int checks = 0;
  int errors = 0;

  // Hand-derived beats for A = 1..16 row-major, B[i][j] = j+1; index [beat][lane].
  logic [DW-1:0] exp_l [7][4] = '{'{1,0,0,0}, '{2,5,0,0}, '{3,6,9,0}, '{4,7,10,13},
                                  '{0,8,11,14}, '{0,0,12,15}, '{0,0,0,16}};
  logic [DW-1:0] exp_u [7][4] = '{'{1,0,0,0}, '{1,2,0,0}, '{1,2,3,0}, '{1,2,3,4},
                                  '{0,2,3,4}, '{0,0,3,4}, '{0,0,0,4}};
  logic [DW-1:0] exp_c [4][4] = '{'{10,20,30,40}, '{26,52,78,104},
                                  '{42,84,126,168}, '{58,116,174,232}};

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
    .busy_o(busy), .done_o(done),
    .left_o_0(left_s[0]), .left_o_4(left_s[1]), .left_o_8(left_s[2]), .left_o_12(left_s[3]),
    .up_o_0(up_s[0]), .up_o_1(up_s[1]), .up_o_2(up_s[2]), .up_o_3(up_s[3])
  );

  // Output-stationary 4x4 array: A flows right, B flows down, each PE accumulates.
  logic [DW-1:0] pa_q [4][4], pb_q [4][4], acc_q [4][4], a_in [4][4], b_in [4][4];
  logic          arr_clr;
  logic [2:0]    dpipe;
  logic          arr_done;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a_in[i][j] = (j == 0) ? left_s[i] : pa_q[i][(j == 0) ? 0 : j-1];
        b_in[i][j] = (i == 0) ? up_s[j]   : pb_q[(i == 0) ? 0 : i-1][j];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || arr_clr) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          pa_q[i][j] <= '0; pb_q[i][j] <= '0; acc_q[i][j] <= '0;
        end
      dpipe <= '0; arr_done <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          pa_q[i][j]  <= a_in[i][j];
          pb_q[i][j]  <= b_in[i][j];
          acc_q[i][j] <= acc_q[i][j] + a_in[i][j] * b_in[i][j];
        end
      dpipe    <= {dpipe[1:0], done};
      arr_done <= arr_done | dpipe[2];
    end
  end

  task automatic wr_el(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; arr_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b want 00", {busy, done});
    end
    checks++;
    if (left_s !== '0 || up_s !== '0) begin
      errors++; $display("FAIL reset_streams got %h %h want 0", left_s, up_s);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    for (int i = 0; i < 16; i++) begin
      wr_el(1'b0, 4'(i), DW'(i + 1));
      wr_el(1'b1, 4'(i), DW'((i % 4) + 1));
    end
    checks++;
    if ({busy, done} !== 2'b00 || left_s !== '0 || up_s !== '0) begin
      errors++; $display("FAIL load_idle got %b %h %h want idle zeros", {busy, done}, left_s, up_s);
    end
  endtask

  task automatic test_basic();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++; $display("FAIL basic_flags beat %0d got %b want 10", k, {busy, done});
      end
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (left_s[r] !== exp_l[k][r]) begin
          errors++; $display("FAIL basic_left beat %0d row %0d got %0d want %0d", k, r, left_s[r], exp_l[k][r]);
        end
        checks++;
        if (up_s[r] !== exp_u[k][r]) begin
          errors++; $display("FAIL basic_up beat %0d col %0d got %0d want %0d", k, r, up_s[r], exp_u[k][r]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01 || left_s !== '0 || up_s !== '0) begin
      errors++; $display("FAIL basic_done got %b %h %h want 01 zeros", {busy, done}, left_s, up_s);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || left_s !== '0 || up_s !== '0) begin
      errors++; $display("FAIL basic_after got %b %h %h want 00 zeros", {busy, done}, left_s, up_s);
    end
  endtask

  task automatic test_array();
    arr_clr = 1'b1;
    @(negedge clk);
    arr_clr = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (arr_done !== 1'b1) begin
      errors++; $display("FAIL array_done got %b want 1", arr_done);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc_q[i][j] !== exp_c[i][j]) begin
          errors++; $display("FAIL array_c[%0d][%0d] got %0d want %0d", i, j, acc_q[i][j], exp_c[i][j]);
        end
      end
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    start = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 99; end
      if (cyc == 8) wr_en = 1'b0;
      if (cyc == 16) start = 1'b0;
      exp_busy = (cyc <= 6) || (cyc >= 9 && cyc <= 15);
      exp_done = (cyc == 7) || (cyc == 16);
      checks++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        errors++; $display("FAIL b2b_flags cyc %0d got %b want %b", cyc, {busy, done}, {exp_busy, exp_done});
      end
      if (cyc <= 6 || (cyc >= 9 && cyc <= 15)) begin
        checks++;
        if (left_s[0] !== exp_l[(cyc >= 9) ? cyc - 9 : cyc][0]) begin
          errors++; $display("FAIL b2b_left0 cyc %0d got %0d want %0d", cyc, left_s[0],
                             exp_l[(cyc >= 9) ? cyc - 9 : cyc][0]);
        end
      end
    end
  endtask

  task automatic test_same_edge_write();
    for (int run = 0; run < 2; run++) begin
      start = 1'b1;
      if (run == 0) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 77; end
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (left_s[1] !== 32'd5) begin
        errors++; $display("FAIL same_edge run %0d beat1 got %0d want 5", run, left_s[1]);
      end
      @(negedge clk);
      checks++;
      if (left_s[1] !== 32'd6) begin
        errors++; $display("FAIL same_edge run %0d beat2 got %0d want 6", run, left_s[1]);
      end
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (left_s[3] !== 32'd13) begin
      errors++; $display("FAIL midrst_beat3 got %0d want 13", left_s[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || left_s !== '0 || up_s !== '0) begin
      errors++; $display("FAIL midrst_async got %b %h %h want 00 zeros", {busy, done}, left_s, up_s);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL midrst_nodone cyc %0d got %b want 0", c, done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (busy !== 1'b1 || left_s !== '0 || up_s !== '0) begin
        errors++; $display("FAIL midrst_zero beat %0d got %b %h %h want busy zeros", k, busy, left_s, up_s);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL midrst_done got %b want 01", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_basic();
    test_array();
    test_back_to_back();
    test_same_edge_write();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
